// File: rtl/fc_pkg.sv
// Shared definitions for the W^T*D accumulator datapath.
//   state_t   : controller states (IDLE, ACC, DONE)
//   acc_width : accumulator width for n-bit signed operands summed over j rows.
//               The product of two n-bit signed values fits in 2n bits.
//               Summing j of them needs ceil(log2(j)) more bits, and j-1 extra
//               bits always covers that.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int acc_width(input int n, input int j);
    return 2 * n + j - 1;
  endfunction

endpackage

// File: rtl/mac_comb.sv
// Combinational multiply-accumulate: S = S0 + sign_extend(A * B).
// Parameters:
//   N : signed operand width
//   K : number of products the running sum must hold without overflow
// Ports:
//   A, B : signed N-bit operands
//   S0   : running sum in
//   S    : running sum out
module mac_comb
  import fc_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic signed [N-1:0]                 A,
  input  logic signed [N-1:0]                 B,
  input  logic signed [acc_width(N, K)-1:0]   S0,
  output logic signed [acc_width(N, K)-1:0]   S
);

  localparam int AW = acc_width(N, K);

  logic signed [2*N-1:0] w_prod;
  logic signed [AW-1:0]  w_prod_ext;

  assign w_prod     = A * B;
  // A signed size cast sign-extends the product.
  // When K=1 the product already has the full accumulator width.
  assign w_prod_ext = AW'(w_prod);
  assign S          = S0 + w_prod_ext;

endmodule

// File: rtl/mxtv_seq_nnbit_jkdim.sv
// Sequential matrix-transpose/vector product o = W^T * D.
// The J rows of W arrive one per accepted in_valid, each with its D element.
// All K columns accumulate in parallel, so one row is absorbed per cycle.
// Parameters:
//   N : signed element width
//   J : rows of W, and length of D
//   K : columns of W, and length of o
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   start     : clears the accumulators and begins a new product
//   in_valid  : qualifies g_input/e_input as the next row
//   g_input   : row r of W; element c at [(c+1)*N-1 -: N]
//   e_input   : D[r]
//   busy      : high while rows are being collected
//   out_valid : one-cycle pulse when o holds the finished product
//   o         : K accumulators, each 2N+J-1 bits wide
module mxtv_seq_nnbit_jkdim
  import fc_pkg::*;
#(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   in_valid,
  input  logic signed [K*N-1:0]                  g_input,
  input  logic signed [N-1:0]                    e_input,
  output logic                                   busy,
  output logic                                   out_valid,
  output logic signed [K*acc_width(N, J)-1:0]    o
);

  localparam int AW = acc_width(N, J);
  // The counter has room to reach J, so it never wraps.
  localparam int CW = $clog2(J + 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(J - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // A row is taken only in ACC.
  // A row that coincides with start is dropped, because start wins.
  assign w_accept  = (r_state == ST_ACC) && in_valid && !start;
  assign busy      = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (start) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (in_valid) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_ROW) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_col
      logic signed [AW-1:0] r_acc;
      logic signed [AW-1:0] w_acc_next;

      mac_comb #(
        .N (N),
        .K (J)
      ) u_mac (
        .A  (g_input[(gi+1)*N-1 -: N]),
        .B  (e_input),
        .S0 (r_acc),
        .S  (w_acc_next)
      );

      always_ff @(posedge clk) begin
        if (rst || start) begin
          r_acc <= '0;
        end else if (w_accept) begin
          r_acc <= w_acc_next;
        end
      end

      assign o[(gi+1)*AW-1 -: AW] = r_acc;
    end
  endgenerate

endmodule

// File: tb/tb_mxtv_seq_nnbit_jkdim.sv
module tb_mxtv_seq_nnbit_jkdim;

  localparam int N  = 8;
  localparam int J  = 3;
  localparam int K  = 3;
  localparam int AW = 2 * N + J - 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      start = 1'b0;
  logic                      in_valid = 1'b0;
  logic signed [K*N-1:0]     g_input = '0;
  logic signed [N-1:0]       e_input = '0;
  logic                      busy;
  logic                      out_valid;
  logic signed [K*AW-1:0]    o;

  int n_checks = 0;
  int n_errors = 0;
  int ov_count = 0;

  mxtv_seq_nnbit_jkdim #(.N(N), .J(J), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .g_input   (g_input),
    .e_input   (e_input),
    .busy      (busy),
    .out_valid (out_valid),
    .o         (o)
  );

  always #5 clk = ~clk;

  // Count out_valid pulses.
  // Sampling on the falling edge keeps this clear of the rising-edge updates.
  always @(negedge clk) if (out_valid) ov_count++;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint o_elem(input int c);
    logic signed [AW-1:0] v;
    v = o[c*AW +: AW];
    return longint'(v);
  endfunction

  task automatic chk_o(input string tag, input longint e0, input longint e1, input longint e2);
    chk({tag, ".o0"}, o_elem(0), e0);
    chk({tag, ".o1"}, o_elem(1), e1);
    chk({tag, ".o2"}, o_elem(2), e2);
  endtask

  // Let the falling-edge monitor update before ov_count is compared.
  task automatic chk_ovc(input string tag, input int exp);
    #1;
    chk(tag, ov_count, exp);
  endtask

  // Call this on a falling edge.
  // It returns on a falling edge, after the row and any idle gap cycles.
  task automatic drive_row(input logic signed [7:0] w0, input logic signed [7:0] w1,
                           input logic signed [7:0] w2, input logic signed [7:0] d,
                           input int gap);
    g_input  = {w2, w1, w0};
    e_input  = d;
    in_valid = 1'b1;
    $display("row W=[%0d,%0d,%0d] D=%0d gap=%0d", w0, w1, w2, d, gap);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("start issued");
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.out_valid", out_valid, 0);
    chk_o("rst", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back rows with D=[1,1,1].
    ov_count = 0;
    do_start();
    chk("t1.busy", busy, 1);
    chk_o("t1.cleared", 0, 0, 0);
    drive_row(1, 2, 3, 1, 0);
    drive_row(4, 5, 6, 1, 0);
    chk("t1.ov_early", out_valid, 0);
    drive_row(7, 8, 9, 1, 0);
    chk("t1.out_valid", out_valid, 1);
    chk("t1.busy_done", busy, 0);
    chk_o("t1", 12, 15, 18);
    @(negedge clk);
    chk("t1.ov_pulse", out_valid, 0);
    chk("t1.busy_idle", busy, 0);
    chk_ovc("t1.ov_count", 1);
    // A row offered while IDLE must leave o unchanged.
    drive_row(50, 50, 50, 3, 1);
    chk_o("t1.idle_hold", 12, 15, 18);
    chk("t1.idle_busy", busy, 0);

    // Every W and D element is -128, the most negative value.
    ov_count = 0;
    do_start();
    for (int r = 0; r < J; r++) drive_row(-128, -128, -128, -128, 0);
    chk("t2.out_valid", out_valid, 1);
    chk_o("t2", 49152, 49152, 49152);
    @(negedge clk);
    chk_ovc("t2.ov_count", 1);

    // Rows separated by 2-cycle gaps, D=[2,-1,0].
    ov_count = 0;
    do_start();
    drive_row(1, 2, 3, 2, 2);
    drive_row(4, 5, 6, -1, 2);
    chk("t3.busy_gap", busy, 1);
    chk_o("t3.partial", -2, -1, 0);
    drive_row(7, 8, 9, 0, 0);
    chk("t3.out_valid", out_valid, 1);
    chk_o("t3", -2, -1, 0);
    @(negedge clk);
    chk_ovc("t3.ov_count", 1);

    // Restart after two of three rows.
    ov_count = 0;
    do_start();
    drive_row(1, 2, 3, 1, 0);
    drive_row(4, 5, 6, 1, 0);
    do_start();
    chk_o("t4.cleared", 0, 0, 0);
    chk_ovc("t4.ov_none", 0);
    drive_row(1, 0, 0, 5, 0);
    drive_row(0, 1, 0, 6, 0);
    chk("t4.ov_early", out_valid, 0);
    drive_row(0, 0, 1, 7, 0);
    chk("t4.out_valid", out_valid, 1);
    chk_o("t4", 5, 6, 7);
    @(negedge clk);
    chk_ovc("t4.ov_count", 1);

    // Reset in the middle of ACC, then a row offered while IDLE.
    ov_count = 0;
    do_start();
    drive_row(1, 2, 3, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_o("t5.rst", 0, 0, 0);
    chk("t5.busy", busy, 0);
    chk("t5.out_valid", out_valid, 0);
    drive_row(9, 9, 9, 9, 1);
    chk_o("t5.idle_hold", 0, 0, 0);
    chk("t5.busy_idle", busy, 0);
    chk_ovc("t5.ov_count", 0);

    // start and in_valid high together: that row is dropped.
    ov_count = 0;
    g_input  = {8'sd10, 8'sd10, 8'sd10};
    e_input  = 8'sd10;
    in_valid = 1'b1;
    start    = 1'b1;
    $display("start with row W=[10,10,10] D=10");
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk_o("t6.dropped", 0, 0, 0);
    drive_row(1, 2, 3, 1, 0);
    drive_row(4, 5, 6, 1, 0);
    chk("t6.busy_2rows", busy, 1);
    chk("t6.ov_2rows", out_valid, 0);
    drive_row(7, 8, 9, 1, 0);
    chk("t6.out_valid", out_valid, 1);
    chk_o("t6", 12, 15, 18);
    @(negedge clk);
    chk_ovc("t6.ov_count", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mxtv_seq_nnbit_jkdim.md
MXTV_SEQ_NNBIT_JKDIM -- requirements
Module: mxtv_seq_nnbit_jkdim

Interface
REQ-001 SHALL have parameter N, default 8: signed element bit-width.
REQ-002 SHALL have parameter J, default 3: rows of W and length of delta vector D; J >= 1.
REQ-003 SHALL have parameter K, default 3: columns of W and length of output vector; K >= 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: begins a new W^T*D computation.
REQ-007 SHALL have port in_valid, input, 1: qualifies g_input/e_input as one row.
REQ-008 SHALL have port g_input, input signed, K*N: row r of W; element c at [(c+1)*N-1 -: N].
REQ-009 SHALL have port e_input, input signed, N: D[r] for the same row.
REQ-010 SHALL have port busy, output, 1: high while in ACC.
REQ-011 SHALL have port out_valid, output, 1: one-cycle pulse when o is final.
REQ-012 SHALL have port o, output signed, K*(2*N+J-1): element c, sum over r of W[r][c]*D[r], at [(c+1)*(2*N+J-1)-1 -: (2*N+J-1)].

Function
REQ-013 SHALL implement FSM states IDLE, ACC and DONE.
REQ-014 SHALL, in any state, on start, clear all K accumulators and the row counter, then enter ACC.
REQ-015 SHALL ignore in_valid in a cycle where start is high; row 0 is the first in_valid after start.
REQ-016 SHALL, in ACC with in_valid high, add sign-extended W[r][c]*D[r] to accumulator c for all c in the same cycle, and increment the row counter.
REQ-017 SHALL, in ACC with in_valid low, hold all state; gaps between rows are allowed.
REQ-018 SHALL, on acceptance of row J-1, enter DONE at the next edge and assert out_valid for exactly that one cycle.
REQ-019 SHALL move from DONE to IDLE after one cycle unless start is high.
REQ-020 SHALL ignore in_valid in IDLE and DONE.
REQ-021 SHALL drive o directly from the accumulators, so o changes only on reset, start, or an accepted row, and holds the final result in IDLE until the next start.
REQ-022 SHALL size the accumulators at 2*N+J-1 signed bits, which is overflow-free for all inputs, including all elements at -2^(N-1).
REQ-023 SHALL size the row counter at $clog2(J+1) bits, and SHALL never let it wrap past J.
REQ-024 SHALL have a latency of one cycle from the accepted row J-1 to out_valid.
REQ-025 SHALL, for J=1, assert out_valid on the cycle after the first accepted row.

Reset
REQ-026 SHALL, on rst, enter IDLE and force busy=0, out_valid=0, o=0 and the row counter to 0.
REQ-027 SHALL give rst priority over start and in_valid.
REQ-028 SHALL, on rst mid-ACC, discard the partial sums with no out_valid.

Structure
REQ-029 SHALL take the state enum and the accumulator width function (2*N+J-1) from shared package fc_pkg.
REQ-030 SHALL instantiate one existing combinational sub-module, mac_comb, per column, with its K parameter set to J: A=W[r][c], B=D[r], S0=acc[c], S=next acc[c].

Verification (N=8, J=3, K=3)
REQ-031 SHALL cover: start; rows [1,2,3],[4,5,6],[7,8,9]; D=[1,1,1] back-to-back -> o=[12,15,18]; out_valid high 1 cycle, 1 cycle after the third row.
REQ-032 SHALL cover: all W and D = -128 -> every element = 49152, with no overflow in 18 bits.
REQ-033 SHALL cover: the REQ-031 rows with 2-cycle in_valid gaps, and D=[2,-1,0] -> o=[-2,-1,0].
REQ-034 SHALL cover: start after 2 of 3 rows, then 3 new rows [1,0,0],[0,1,0],[0,0,1] with D=[5,6,7] -> o=[5,6,7]; no out_valid before restart completes.
REQ-035 SHALL cover: rst asserted after row 1 -> o=0, busy=0, no out_valid; in_valid in IDLE -> o unchanged.
REQ-036 SHALL cover: start and in_valid high in the same cycle -> that row ignored; three more rows are needed for out_valid.
